// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO registers: 32-cycle shift-add multiply,
// 32-cycle restoring divide, one fix-up cycle for signs, plus MTHI/MTLO writes.
module muldiv_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] valA,
    input  logic [DATA_W-1:0] valB,
    input  logic              cancel,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    state_t                r_state;
    state_t                w_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_W-1:0]     r_a;
    logic [DATA_W-1:0]     r_b;
    logic [DATA_W-1:0]     r_orig_a;
    logic [2*DATA_W-1:0]   r_acc;
    logic                  r_is_div;
    logic                  r_div0;
    logic                  r_neg_q;
    logic                  r_neg_r;
    logic [DATA_W-1:0]     r_hi;
    logic [DATA_W-1:0]     r_lo;
    logic                  r_done;

    logic                  w_idle_go;
    logic                  w_issue;
    logic                  w_mt;
    logic                  w_sgn;
    logic [DATA_W:0]       w_mul_sum;
    logic [DATA_W:0]       w_rem_sh;
    logic [DATA_W:0]       w_rem_sub;
    logic                  w_q_bit;
    logic [2*DATA_W-1:0]   w_prod;
    logic [DATA_W-1:0]     w_quot;
    logic [DATA_W-1:0]     w_rem;

    function automatic logic [DATA_W-1:0] f_abs(input logic [DATA_W-1:0] x, input logic sgn);
        f_abs = (sgn && x[DATA_W-1]) ? (~x + DATA_W'(1)) : x;
    endfunction

    assign w_idle_go = (r_state == S_IDLE) && start && !cancel;
    assign w_issue   = w_idle_go && (op[2] == 1'b0);
    assign w_mt      = w_idle_go && (op[2:1] == 2'b10);
    assign w_sgn     = ~op[0];

    // Multiply: add multiplicand into the upper half, then shift the 64-bit pair right.
    assign w_mul_sum = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + {1'b0, (r_b[0] ? r_a : '0)};
    // Divide: shift next dividend bit into the partial remainder; no borrow means quotient bit 1.
    assign w_rem_sh  = {r_acc[2*DATA_W-1:DATA_W], r_a[DATA_W-1]};
    assign w_rem_sub = w_rem_sh - {1'b0, r_b};
    assign w_q_bit   = ~w_rem_sub[DATA_W];

    assign w_prod = r_neg_q ? (~r_acc + (2*DATA_W)'(1)) : r_acc;
    assign w_quot = r_neg_q ? (~r_acc[DATA_W-1:0] + DATA_W'(1)) : r_acc[DATA_W-1:0];
    assign w_rem  = r_neg_r ? (~r_acc[2*DATA_W-1:DATA_W] + DATA_W'(1))
                            : r_acc[2*DATA_W-1:DATA_W];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; cancel overrides both iteration and completion.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_issue) w_next = S_RUN;
                else         w_next = S_IDLE;
            end
            S_RUN: begin
                if (cancel)                w_next = S_IDLE;
                else if (r_cnt == LAST_CNT) w_next = S_FIX;
                else                       w_next = S_RUN;
            end
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs decoded from state.
    always_comb begin
        busy = 1'b0;
        case (r_state)
            S_RUN:   busy = 1'b1;
            S_FIX:   busy = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    // Datapath, HI/LO and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_orig_a <= '0;
            r_acc    <= '0;
            r_is_div <= 1'b0;
            r_div0   <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_a      <= f_abs(valA, w_sgn);
                        r_b      <= f_abs(valB, w_sgn);
                        r_orig_a <= valA;
                        r_neg_q  <= w_sgn & (valA[DATA_W-1] ^ valB[DATA_W-1]);
                        r_neg_r  <= w_sgn & valA[DATA_W-1];
                        r_is_div <= op[1];
                        r_div0   <= (valB == '0);
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end else if (w_mt) begin
                        if (op[0]) r_lo <= valA;
                        else       r_hi <= valA;
                    end
                end
                S_RUN: begin
                    if (!cancel) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_is_div) begin
                            r_a   <= {r_a[DATA_W-2:0], 1'b0};
                            r_acc <= {(w_q_bit ? w_rem_sub[DATA_W-1:0] : w_rem_sh[DATA_W-1:0]),
                                      r_acc[DATA_W-2:0], w_q_bit};
                        end else begin
                            r_b   <= {1'b0, r_b[DATA_W-1:1]};
                            r_acc <= {w_mul_sum, r_acc[DATA_W-1:1]};
                        end
                    end
                end
                S_FIX: begin
                    if (!cancel) begin
                        r_done <= 1'b1;
                        if (r_is_div && r_div0) begin
                            r_lo <= '1;
                            r_hi <= r_orig_a;
                        end else if (r_is_div) begin
                            r_lo <= w_quot;
                            r_hi <= w_rem;
                        end else begin
                            r_hi <= w_prod[2*DATA_W-1:DATA_W];
                            r_lo <= w_prod[DATA_W-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
